// File: rtl/prbs_checker.sv
// Serial PRBS receive checker: self-seeds a Fibonacci LFSR from the incoming stream,
// verifies it, then counts bit errors and checked bits while locked.
module prbs_checker #(
    parameter int unsigned           LFSR_LEN    = 7,
    parameter logic [LFSR_LEN-1:0]   TAPS        = 7'h60,
    parameter int unsigned           LOCK_COUNT  = 16,
    parameter int unsigned           WINDOW      = 64,
    parameter int unsigned           UNLOCK_ERRS = 4,
    parameter int unsigned           CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d,
    input  logic             d_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam int unsigned SEED_W  = $clog2(LFSR_LEN + 1);
    localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned WBIT_W  = $clog2(WINDOW + 1);
    localparam int unsigned WERR_W  = $clog2(UNLOCK_ERRS + 1);

    // state     | meaning
    // ST_SEED   | shifting received bits into the LFSR
    // ST_VERIFY | free-running LFSR, counting consecutive matches
    // ST_LOCKED | free-running LFSR, counting errors and checked bits
    typedef enum logic [1:0] {ST_SEED, ST_VERIFY, ST_LOCKED} state_t;

    state_t              r_state,     w_state_nxt;
    logic [LFSR_LEN-1:0] r_lfsr,      w_lfsr_nxt;
    logic [SEED_W-1:0]   r_seed_cnt,  w_seed_nxt;
    logic [MATCH_W-1:0]  r_match_cnt, w_match_nxt;
    logic [WBIT_W-1:0]   r_win_bits,  w_win_bits_nxt;
    logic [WERR_W-1:0]   r_win_errs,  w_win_errs_nxt;
    logic                r_locked;
    logic                r_err_pulse;
    logic [CNT_W-1:0]    r_err_count, w_err_count_nxt, w_err_base;
    logic [CNT_W-1:0]    r_bit_count, w_bit_count_nxt, w_bit_base;
    logic                w_exp;
    logic                w_err_hit;
    logic                w_bit_inc;
    logic [LFSR_LEN-1:0] w_seed_shift;

    assign w_exp        = ^(r_lfsr & TAPS);
    assign w_seed_shift = {r_lfsr[LFSR_LEN-2:0], d};

    always_comb begin
        w_state_nxt    = r_state;
        w_lfsr_nxt     = r_lfsr;
        w_seed_nxt     = r_seed_cnt;
        w_match_nxt    = r_match_cnt;
        w_win_bits_nxt = r_win_bits;
        w_win_errs_nxt = r_win_errs;
        w_err_hit      = 1'b0;
        w_bit_inc      = 1'b0;
        if (d_valid) begin
            case (r_state)
                ST_SEED: begin
                    w_lfsr_nxt = w_seed_shift;
                    if (r_seed_cnt == SEED_W'(LFSR_LEN - 1)) begin
                        w_seed_nxt = '0;
                        if (w_seed_shift != '0) begin
                            w_state_nxt = ST_VERIFY;
                            w_match_nxt = '0;
                        end
                    end else begin
                        w_seed_nxt = r_seed_cnt + SEED_W'(1);
                    end
                end
                ST_VERIFY: begin
                    w_lfsr_nxt = {r_lfsr[LFSR_LEN-2:0], w_exp};
                    if (d == w_exp) begin
                        if (r_match_cnt == MATCH_W'(LOCK_COUNT - 1)) begin
                            w_state_nxt    = ST_LOCKED;
                            w_win_bits_nxt = '0;
                            w_win_errs_nxt = '0;
                        end else begin
                            w_match_nxt = r_match_cnt + MATCH_W'(1);
                        end
                    end else begin
                        w_state_nxt = ST_SEED;
                        w_seed_nxt  = '0;
                    end
                end
                ST_LOCKED: begin
                    w_lfsr_nxt = {r_lfsr[LFSR_LEN-2:0], w_exp};
                    w_bit_inc  = 1'b1;
                    w_err_hit  = (d != w_exp);
                    // An unlocking error takes priority over the window wrap on the same beat.
                    if (w_err_hit && (r_win_errs == WERR_W'(UNLOCK_ERRS - 1))) begin
                        w_state_nxt    = ST_SEED;
                        w_seed_nxt     = '0;
                        w_win_bits_nxt = '0;
                        w_win_errs_nxt = '0;
                    end else if (r_win_bits == WBIT_W'(WINDOW - 1)) begin
                        w_win_bits_nxt = '0;
                        w_win_errs_nxt = '0;
                    end else begin
                        w_win_bits_nxt = r_win_bits + WBIT_W'(1);
                        w_win_errs_nxt = r_win_errs + WERR_W'(w_err_hit);
                    end
                end
                default: begin
                    w_state_nxt = ST_SEED;
                    w_seed_nxt  = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_err_base      = clr_cnt ? '0 : r_err_count;
        w_bit_base      = clr_cnt ? '0 : r_bit_count;
        w_err_count_nxt = w_err_base;
        w_bit_count_nxt = w_bit_base;
        if (w_err_hit && (w_err_base != '1)) begin
            w_err_count_nxt = w_err_base + CNT_W'(1);
        end
        if (w_bit_inc && (w_bit_base != '1)) begin
            w_bit_count_nxt = w_bit_base + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_SEED;
            r_lfsr      <= '0;
            r_seed_cnt  <= '0;
            r_match_cnt <= '0;
            r_win_bits  <= '0;
            r_win_errs  <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
            r_bit_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_lfsr      <= w_lfsr_nxt;
            r_seed_cnt  <= w_seed_nxt;
            r_match_cnt <= w_match_nxt;
            r_win_bits  <= w_win_bits_nxt;
            r_win_errs  <= w_win_errs_nxt;
            r_locked    <= (w_state_nxt == ST_LOCKED);
            r_err_pulse <= w_err_hit;
            r_err_count <= w_err_count_nxt;
            r_bit_count <= w_bit_count_nxt;
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;
    assign bit_count = r_bit_count;

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: a behavioural checker model predicts every
// registered output per cycle; a negedge monitor pops and compares.
module tb_prbs_checker;

    localparam int LEN    = 7;
    localparam int LOCKN  = 16;
    localparam int WIN    = 64;
    localparam int UNL    = 4;
    localparam int CMAX   = 65535;
    localparam int PERIOD = 127;

    logic        clk;
    logic        rst_n;
    logic        d;
    logic        d_valid;
    logic        clr_cnt;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [15:0] bit_count;

    prbs_checker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d         (d),
        .d_valid   (d_valid),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .bit_count (bit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit lck;
        bit pls;
        int ec;
        int bc;
    } exp_t;
    exp_t exp_q[$];

    // Transmit side: one full period of x^7+x^6+1 starting with seed 7'h7F
    bit prbs[PERIOD];
    int tx_ptr;

    // Checker model state: 0 = seeding, 1 = verifying, 2 = locked
    bit [6:0] taps_v;
    bit       m_seq[$];
    int       m_state, m_seed, m_match, m_wbits, m_werrs, m_ec, m_bc;
    bit       m_pulse;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_seq.delete();
        for (int i = 0; i < LEN; i++) m_seq.push_back(1'b0);
        m_state = 0; m_seed = 0; m_match = 0;
        m_wbits = 0; m_werrs = 0; m_ec = 0; m_bc = 0; m_pulse = 0;
    endfunction

    function automatic void shift_in(input bit b);
        m_seq.push_back(b);
        void'(m_seq.pop_front());
    endfunction

    function automatic void model_step(input bit b, input bit v, input bit clr);
        bit e;
        bit any;
        m_pulse = 0;
        if (clr) begin
            m_ec = 0;
            m_bc = 0;
        end
        if (v) begin
            // m_seq[LEN-1] is the newest bit, i.e. lfsr bit 0
            e = 0;
            for (int i = 0; i < LEN; i++)
                if (taps_v[i]) e ^= m_seq[LEN-1-i];
            if (m_state == 0) begin
                shift_in(b);
                m_seed++;
                if (m_seed == LEN) begin
                    m_seed = 0;
                    any = 0;
                    foreach (m_seq[k]) any |= m_seq[k];
                    if (any) begin
                        m_state = 1;
                        m_match = 0;
                    end
                end
            end else if (m_state == 1) begin
                shift_in(e);
                if (b == e) begin
                    m_match++;
                    if (m_match == LOCKN) begin
                        m_state = 2; m_wbits = 0; m_werrs = 0;
                    end
                end else begin
                    m_state = 0;
                    m_seed  = 0;
                end
            end else begin
                shift_in(e);
                if (m_bc < CMAX) m_bc++;
                m_wbits++;
                if (b != e) begin
                    m_pulse = 1;
                    if (m_ec < CMAX) m_ec++;
                    m_werrs++;
                end
                if (m_werrs == UNL) begin
                    m_state = 0; m_seed = 0; m_wbits = 0; m_werrs = 0;
                end else if (m_wbits == WIN) begin
                    m_wbits = 0; m_werrs = 0;
                end
            end
        end
    endfunction

    function automatic void push_exp();
        exp_t x;
        x.lck = (m_state == 2);
        x.pls = m_pulse;
        x.ec  = m_ec;
        x.bc  = m_bc;
        exp_q.push_back(x);
    endfunction

    // Called just after a posedge; drives one beat, then returns #1 after the next posedge.
    task automatic send_bit(input bit b, input bit v, input bit clr);
        d = b; d_valid = v; clr_cnt = clr;
        @(posedge clk);
        model_step(b, v, clr);
        push_exp();
        #1;
    endtask

    task automatic send_prbs(input bit v, input bit inj, input bit clr);
        bit b;
        if (v) begin
            b = prbs[tx_ptr] ^ inj;
            tx_ptr = (tx_ptr + 1) % PERIOD;
        end else begin
            b = 1'($urandom);
        end
        send_bit(b, v, clr);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_pulse"},  int'(err_pulse), 0);
        chk({tag, "_errc"},   int'(err_count), 0);
        chk({tag, "_bitc"},   int'(bit_count), 0);
    endtask

    // Asserts reset between edges, checks outputs clear at once, holds with toggling inputs.
    task automatic do_reset(input int hold);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_zero_outputs("rst_now");
        for (int i = 0; i < hold; i++) begin
            d = 1'($urandom); d_valid = 1'($urandom); clr_cnt = 1'($urandom);
            @(posedge clk);
            push_exp();
            #1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        d_valid = 1'b0; clr_cnt = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("mon_locked", int'(locked),    int'(e.lck));
            chk("mon_pulse",  int'(err_pulse), int'(e.pls));
            chk("mon_errc",   int'(err_count), e.ec);
            chk("mon_bitc",   int'(bit_count), e.bc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        taps_v = 7'h60;
        for (int i = 0; i < PERIOD; i++)
            prbs[i] = (i < LEN) ? 1'b1 : (prbs[i-7] ^ prbs[i-6]);
        tx_ptr = 0;
        model_reset();

        // Power-on reset held 3 cycles with toggling inputs
        rst_n = 1'b0; d = 1'b0; d_valid = 1'b0; clr_cnt = 1'b0;
        #1;
        chk_zero_outputs("por");
        for (int i = 0; i < 3; i++) begin
            d = 1'($urandom); d_valid = 1'($urandom); clr_cnt = 1'($urandom);
            @(posedge clk);
            push_exp();
            #1;
        end
        @(negedge clk);
        rst_n = 1'b1; d_valid = 1'b0; clr_cnt = 1'b0;

        // Clean stream from seed 7F: lock the cycle after beat 23
        for (int n = 1; n <= 40; n++) begin
            send_prbs(1, 0, 0);
            if (n == 22) chk("lock_early", int'(locked), 0);
            if (n == 23) chk("lock_at_23", int'(locked), 1);
        end
        chk("clean_bitc", int'(bit_count), 40 - 23);
        chk("clean_errc", int'(err_count), 0);

        // Single error while locked
        send_prbs(1, 1, 0);
        chk("single_pulse",  int'(err_pulse), 1);
        chk("single_errc",   int'(err_count), 1);
        chk("single_locked", int'(locked), 1);
        send_prbs(1, 0, 0);
        chk("single_pulse_end", int'(err_pulse), 0);
        for (int n = 0; n < 10; n++) send_prbs(1, 0, 0);
        chk("single_bitc", int'(bit_count), 17 + 12);

        // Four errors inside one window drop lock; clean stream re-locks 23 beats later
        do_reset(2);
        for (int n = 0; n < 28; n++) send_prbs(1, 0, 0);
        for (int k = 1; k <= UNL; k++) begin
            int gap;
            gap = $urandom_range(0, 5);
            for (int g = 0; g < gap; g++) send_prbs(1, 0, 0);
            send_prbs(1, 1, 0);
        end
        chk("unlock_locked", int'(locked), 0);
        chk("unlock_errc",   int'(err_count), 4);
        chk("unlock_pulse",  int'(err_pulse), 1);
        for (int n = 1; n <= 23; n++) begin
            send_prbs(1, 0, 0);
            if (n == 22) chk("relock_early", int'(locked), 0);
        end
        chk("relock_locked", int'(locked), 1);
        chk("relock_errc",   int'(err_count), 4);

        // All-zero stream never locks; then clean stream with alternating valid
        do_reset(1);
        for (int n = 0; n < 200; n++) send_bit(1'b0, 1, 0);
        chk("zeros_locked", int'(locked), 0);
        chk("zeros_errc",   int'(err_count), 0);
        chk("zeros_bitc",   int'(bit_count), 0);
        for (int n = 0; n < 100; n++) send_prbs(n % 2 == 0, 0, 0);
        chk("toggle_locked", int'(locked), 1);

        // clr_cnt on the same beat as an error leaves err_count=1
        send_prbs(1, 1, 0);
        for (int n = 0; n < 5; n++) send_prbs(1, 0, 0);
        send_prbs(1, 1, 0);
        for (int n = 0; n < 5; n++) send_prbs(1, 0, 0);
        chk("preclr_errc", int'(err_count), 2);
        send_prbs(1, 1, 1);
        chk("clr_errc",   int'(err_count), 1);
        chk("clr_bitc",   int'(bit_count), 1);
        chk("clr_locked", int'(locked), 1);
        for (int n = 0; n < 3; n++) send_prbs(1, 0, 0);

        // Mid-stream reset, then re-lock on the continuing stream
        do_reset(2);
        for (int n = 1; n <= 23; n++) begin
            send_prbs(1, 0, 0);
            if (n == 22) chk("rst_relock_early", int'(locked), 0);
        end
        chk("rst_relock", int'(locked), 1);

        // Randomised soak: sparse valid gaps, errors and clears
        for (int n = 0; n < 400; n++) begin
            bit v;
            v = ($urandom_range(0, 3) != 0);
            send_prbs(v, v && ($urandom_range(0, 15) == 0), $urandom_range(0, 31) == 0);
        end

        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
